// File: rtl/i2c_reg_mailbox_pkg.sv
// Shared constants for the I2C register mailbox: register map, bit indices, level width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package i2c_reg_mailbox_pkg;

    // Register map (byte addresses as seen by the upstream i2c_slave)
    localparam int ADDR_STATUS   = 'h00;
    localparam int ADDR_DATA     = 'h01;
    localparam int ADDR_TX_LEVEL = 'h02;
    localparam int ADDR_RX_LEVEL = 'h03;
    localparam int ADDR_CONTROL  = 'h04;
    localparam int ADDR_IRQ_EN   = 'h05;

    // STATUS bit positions; bits 7:6 read as zero
    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_RX_FULL      = 2;
    localparam int ST_RX_EMPTY     = 3;
    localparam int ST_TX_OVERFLOW  = 4;
    localparam int ST_RX_UNDERFLOW = 5;

    // CONTROL bit positions (write-1, self-clearing, never stored)
    localparam int CTRL_FLUSH_TX    = 0;
    localparam int CTRL_FLUSH_RX    = 1;
    localparam int CTRL_CLEAR_FLAGS = 2;

    // IRQ_EN bit positions
    localparam int IRQ_RX_NOT_EMPTY = 0;
    localparam int IRQ_TX_EMPTY     = 1;
    localparam int IRQ_STICKY       = 2;
    localparam int IRQ_EN_WIDTH     = 3;

    // Register-access handshake states
    typedef enum logic [2:0] {
        ACC_WAIT_LOW = 3'd0,  // request must be seen low before an edge can count
        ACC_IDLE     = 3'd1,  // request low, waiting for a rising edge
        ACC_DETECT   = 3'd2,  // rising edge seen, access is executed this cycle
        ACC_HOLD     = 3'd3   // response high until request falls
    } acc_state_t;

    // A level counter must hold 0..depth inclusive, hence one bit more than the pointer
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2c_reg_mailbox_fifo.sv
// Byte FIFO for the mailbox (module mailbox_fifo): synchronous, single clock, with flush.
// Latency: push visible at head/level one cycle later; head is the combinational read of mem[rd_ptr].
// Backpressure: push ignored when full unless a pop lands the same cycle; pop ignored when empty; flush wins.
module mailbox_fifo
    import i2c_reg_mailbox_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    head,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          full,
    output logic                          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign head  = mem[rd_ptr];

    // A full FIFO still takes a push when the head leaves in the same cycle;
    // a flush discards both so the FIFO ends up truly empty.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // Storage array: data only, no reset needed since count gates visibility
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_reg_mailbox.sv
// Register-mapped byte mailbox between an I2C slave register port and two byte streams (optional irq: I2C_REG_MAILBOX_IRQ_EN).
// Latency: access executes the cycle after the reg_request rising edge; reg_response/reg_read_data rise the cycle after that.
// Backpressure: tx_valid/tx_ready and rx_valid/rx_ready handshakes; a DATA write to a full TX FIFO drops the byte and sets tx_overflow.
module i2c_reg_mailbox #(
    parameter int FIFO_DEPTH        = 16,
    parameter int REG_ADDRESS_WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [REG_ADDRESS_WIDTH-1:0] reg_address,
    input  logic                         reg_is_write,
    input  logic                         reg_request,
    output logic                         reg_response,
    output logic [7:0]                   reg_read_data,
    input  logic [7:0]                   reg_write_data,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic                         irq
);

    import i2c_reg_mailbox_pkg::*;

    localparam int LW = level_width(FIFO_DEPTH);

    // FIFO status
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_empty;
    logic [7:0]    tx_head;
    logic [7:0]    rx_head;

    // Access decode and actions
    acc_state_t    acc_state;
    logic [31:0]   addr_ext;
    logic          acc_ok;
    logic          sel_data;
    logic          sel_control;
    logic          sel_irq_en;
    logic [7:0]    rd_val;
    logic [7:0]    status;
    logic          do_access;
    logic          data_write;
    logic          data_read;
    logic          control_write;
    logic          irq_en_write;

    // Stream handshakes and FIFO controls
    logic          tx_pop;
    logic          rx_push;
    logic          rx_pop;
    logic          flush_tx;
    logic          flush_rx;
    logic          clear_flags;
    logic          set_overflow;
    logic          set_underflow;
    logic          tx_overflow;
    logic          rx_underflow;
    logic [7:0]    irq_en_rd;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_head;
    assign rx_ready = !rx_full;
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_push  = rx_valid && rx_ready;

    // Zero-extend the address so the decode works for any REG_ADDRESS_WIDTH up to 32
    assign addr_ext = 32'(reg_address);

    // STATUS register composition
    always_comb begin
        status                  = 8'h00;
        status[ST_TX_FULL]      = tx_full;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_RX_FULL]      = rx_full;
        status[ST_RX_EMPTY]     = rx_empty;
        status[ST_TX_OVERFLOW]  = tx_overflow;
        status[ST_RX_UNDERFLOW] = rx_underflow;
    end

    // Address decode: which accesses are legal (and acknowledged) and what a read returns
    always_comb begin
        acc_ok      = 1'b0;
        sel_data    = 1'b0;
        sel_control = 1'b0;
        sel_irq_en  = 1'b0;
        rd_val      = 8'h00;
        case (addr_ext)
            ADDR_STATUS: begin
                acc_ok = !reg_is_write;
                rd_val = status;
            end
            ADDR_DATA: begin
                acc_ok   = 1'b1;
                sel_data = 1'b1;
                // An underflowing read returns zero rather than stale memory
                rd_val   = rx_empty ? 8'h00 : rx_head;
            end
            ADDR_TX_LEVEL: begin
                acc_ok = !reg_is_write;
                rd_val = 8'(tx_level);
            end
            ADDR_RX_LEVEL: begin
                acc_ok = !reg_is_write;
                rd_val = 8'(rx_level);
            end
            ADDR_CONTROL: begin
                acc_ok      = reg_is_write;
                sel_control = 1'b1;
            end
`ifdef I2C_REG_MAILBOX_IRQ_EN
            ADDR_IRQ_EN: begin
                acc_ok     = 1'b1;
                sel_irq_en = 1'b1;
                rd_val     = irq_en_rd;
            end
`endif
            default: begin
                acc_ok = 1'b0;
            end
        endcase
        if (reg_is_write) begin
            rd_val = 8'h00;
        end
    end

    // The access fires exactly once, in the DETECT cycle, and only if the request is still held
    assign do_access     = (acc_state == ACC_DETECT) && reg_request && acc_ok;
    assign data_write    = do_access && reg_is_write && sel_data;
    assign data_read     = do_access && !reg_is_write && sel_data;
    assign control_write = do_access && reg_is_write && sel_control;
    assign irq_en_write  = do_access && reg_is_write && sel_irq_en;

    assign flush_tx      = control_write && reg_write_data[CTRL_FLUSH_TX];
    assign flush_rx      = control_write && reg_write_data[CTRL_FLUSH_RX];
    assign clear_flags   = control_write && reg_write_data[CTRL_CLEAR_FLAGS];
    assign set_overflow  = data_write && tx_full && !tx_pop;
    assign set_underflow = data_read && rx_empty;
    assign rx_pop        = data_read && !rx_empty;

    // Register-port handshake FSM with registered response and read data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Starting in WAIT_LOW means a request held across reset is not a new edge
            acc_state     <= ACC_WAIT_LOW;
            reg_response  <= 1'b0;
            reg_read_data <= 8'h00;
        end else begin
            case (acc_state)
                ACC_WAIT_LOW: begin
                    if (!reg_request) begin
                        acc_state <= ACC_IDLE;
                    end
                end
                ACC_IDLE: begin
                    if (reg_request) begin
                        acc_state <= ACC_DETECT;
                    end
                end
                ACC_DETECT: begin
                    if (!reg_request) begin
                        // Dropped before acknowledgement: nothing was executed
                        acc_state <= ACC_IDLE;
                    end else if (acc_ok) begin
                        acc_state     <= ACC_HOLD;
                        reg_response  <= 1'b1;
                        reg_read_data <= rd_val;
                    end else begin
                        // Illegal access: never acknowledged, wait for the master to give up
                        acc_state <= ACC_WAIT_LOW;
                    end
                end
                ACC_HOLD: begin
                    if (!reg_request) begin
                        acc_state     <= ACC_IDLE;
                        reg_response  <= 1'b0;
                        reg_read_data <= 8'h00;
                    end
                end
                default: begin
                    acc_state <= ACC_WAIT_LOW;
                end
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
        end else begin
            if (set_overflow) begin
                tx_overflow <= 1'b1;
            end else if (clear_flags) begin
                tx_overflow <= 1'b0;
            end
            if (set_underflow) begin
                rx_underflow <= 1'b1;
            end else if (clear_flags) begin
                rx_underflow <= 1'b0;
            end
        end
    end

`ifdef I2C_REG_MAILBOX_IRQ_EN
    logic [IRQ_EN_WIDTH-1:0] irq_en;
    logic [IRQ_EN_WIDTH-1:0] irq_src;
    logic                    irq_q;

    assign irq_en_rd = {{(8-IRQ_EN_WIDTH){1'b0}}, irq_en};

    // Interrupt sources in IRQ_EN bit order
    always_comb begin
        irq_src                   = '0;
        irq_src[IRQ_RX_NOT_EMPTY] = !rx_empty;
        irq_src[IRQ_TX_EMPTY]     = tx_empty;
        irq_src[IRQ_STICKY]       = tx_overflow || rx_underflow;
    end

    // IRQ_EN register and the registered interrupt level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_en <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (irq_en_write) begin
                irq_en <= reg_write_data[IRQ_EN_WIDTH-1:0];
            end
            irq_q <= |(irq_en & irq_src);
        end
    end

    assign irq = irq_q;
`else
    assign irq_en_rd = 8'h00;
    assign irq       = 1'b0;
`endif

    // Host-to-fabric FIFO: filled by DATA writes, drained by the tx stream
    mailbox_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush_tx),
        .push      (data_write),
        .push_data (reg_write_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .level     (tx_level),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // Fabric-to-host FIFO: filled by the rx stream, drained by DATA reads
    mailbox_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush_rx),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .level     (rx_level),
        .full      (rx_full),
        .empty     (rx_empty)
    );

endmodule
